step_counter_gen: RTL

Parametrised multi-step up/down counter. It is the next-generation replacement for the fixed 4-bit +3/+1 step counter. Width, limit, both step sizes and the wrap policy are set by parameters. It adds down-counting, a terminal-count pulse and a sticky overflow flag, and serves as the general event/step counter in lab datapaths.

---
 rtl/step_counter_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/step_counter_gen.sv
// ============================================================================
// step_counter_gen
// ----------------------------------------------------------------------------
// Parametrised multi-step up/down counter with terminal-count pulse and a
// sticky overflow flag. Replaces the older fixed 4-bit +3/+1 step counter.
//
// Parameters:
//   WIDTH     - counter and data width in bits (2..16)
//   LIMIT     - highest legal count value (1..2^WIDTH-1)
//   STEP_A    - increment for mode 00 (1..LIMIT)
//   STEP_B    - increment for mode 01, decrement for mode 10 (1..LIMIT)
//   WRAP_MODE - 0: clear-on-wrap, 1: modulo (LIMIT+1) wrap
//
// Ports:
//   clk      in   posedge clock
//   reset    in   asynchronous active-low reset
//   load     in   parallel load strobe (highest priority after reset)
//   count_en in   count enable
//   c        in   mode: 00 +STEP_A, 01 +STEP_B, 10 -STEP_B, 11 hold
//   data_in  in   parallel load value (saturated to LIMIT)
//   clr_ovf  in   synchronous clear of the ovf flag
//   count    out  registered count value
//   tc       out  registered one-cycle terminal-count pulse
//   ovf      out  registered sticky wrap flag
// ============================================================================
module step_counter_gen #(
    parameter int WIDTH     = 8,
    parameter int LIMIT     = 254,
    parameter int STEP_A    = 3,
    parameter int STEP_B    = 1,
    parameter int WRAP_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic [1:0]       c,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Elaboration-time parameter checks: an illegal configuration must not
    // build silently.
    if (WIDTH < 2 || WIDTH > 16) begin : g_badWidth
        $error("step_counter_gen: WIDTH must be in 2..16");
    end
    if (LIMIT < 1 || LIMIT > ((1 << WIDTH) - 1)) begin : g_badLimit
        $error("step_counter_gen: LIMIT must be in 1..2^WIDTH-1");
    end
    if (STEP_A < 1 || STEP_A > LIMIT) begin : g_badStepA
        $error("step_counter_gen: STEP_A must be in 1..LIMIT");
    end
    if (STEP_B < 1 || STEP_B > LIMIT) begin : g_badStepB
        $error("step_counter_gen: STEP_B must be in 1..LIMIT");
    end
    if (WRAP_MODE != 0 && WRAP_MODE != 1) begin : g_badWrap
        $error("step_counter_gen: WRAP_MODE must be 0 or 1");
    end

    typedef enum logic [1:0] {
        MODE_UP_A   = 2'b00,
        MODE_UP_B   = 2'b01,
        MODE_DOWN_B = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Arithmetic is done one bit wider than the counter so that the limit
    // check sees the true sum and never a truncated value.
    localparam logic [WIDTH:0]   LIMIT_W   = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   MODULUS_W = (WIDTH+1)'(LIMIT + 1);
    localparam logic [WIDTH:0]   STEP_A_W  = (WIDTH+1)'(STEP_A);
    localparam logic [WIDTH:0]   STEP_B_W  = (WIDTH+1)'(STEP_B);
    localparam logic [WIDTH-1:0] LIMIT_N   = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    mode_t            w_mode;
    logic [WIDTH:0]   w_cur;
    logic [WIDTH:0]   w_upSum;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_nextTc;
    logic             w_nextOvf;

    assign w_mode  = mode_t'(c);
    assign w_cur   = {1'b0, r_count};
    assign w_upSum = w_cur + ((w_mode == MODE_UP_A) ? STEP_A_W : STEP_B_W);

    // Next-state selection: load beats counting, counting beats idle. Any
    // branch that does not wrap drives tc low so the pulse lasts one cycle.
    always_comb begin
        w_nextCount = r_count;
        w_nextTc    = 1'b0;
        if (load) begin
            w_nextCount = ({1'b0, data_in} > LIMIT_W) ? LIMIT_N : data_in;
        end else if (count_en) begin
            unique case (w_mode)
                MODE_UP_A, MODE_UP_B: begin
                    if (w_upSum <= LIMIT_W) begin
                        w_nextCount = WIDTH'(w_upSum);
                    end else begin
                        w_nextTc    = 1'b1;
                        w_nextCount = (WRAP_MODE == 1) ? WIDTH'(w_upSum - MODULUS_W)
                                                       : '0;
                    end
                end
                MODE_DOWN_B: begin
                    if (w_cur >= STEP_B_W) begin
                        w_nextCount = WIDTH'(w_cur - STEP_B_W);
                    end else begin
                        w_nextTc    = 1'b1;
                        w_nextCount = (WRAP_MODE == 1) ? WIDTH'(w_cur + MODULUS_W - STEP_B_W)
                                                       : LIMIT_N;
                    end
                end
                default: begin
                    w_nextCount = r_count;
                end
            endcase
        end
    end

    // A wrap on the same edge as clr_ovf keeps the flag set.
    assign w_nextOvf = w_nextTc | (r_ovf & ~clr_ovf);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_tc    <= w_nextTc;
            r_ovf   <= w_nextOvf;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
